// File: rtl/gfx_pixel_rmw_ctrl.sv
// Single-pixel read / write / read-modify-write sequencer with a one-word cache.
// Pixel packing and unpacking sit in two small helper modules that share MDW.

module color_to_memory #(
    parameter int MDW = 256
) (
    input  logic             rmw,
    input  logic [5:0]       bpp,
    input  logic [31:0]      color,
    input  logic [7:0]       mb,
    input  logic [MDW-1:0]   mem_i,
    output logic [MDW-1:0]   dat,
    output logic [MDW/8-1:0] sel
);
    localparam int SW = MDW / 8;

    logic [31:0]    mask;
    logic [3:0]     sel1;
    logic [MDW-1:0] field;

    always_comb begin
        mask = (bpp >= 6'd32) ? '1 : ((32'd1 << bpp) - 32'd1);
        if (bpp == 6'd0)       sel1 = 4'hF;
        else if (bpp <= 6'd8)  sel1 = 4'h1;
        else if (bpp <= 6'd16) sel1 = 4'h3;
        else if (bpp <= 6'd24) sel1 = 4'h7;
        else                   sel1 = 4'hF;
        // Merge into the cached word so bytes enabled around the pixel keep their contents.
        field = MDW'(mask) << mb;
        dat   = (mem_i & ~field) | (MDW'(color & mask) << mb);
        sel   = rmw ? '1 : (SW'(sel1) << mb[7:3]);
    end
endmodule

module memory_to_color #(
    parameter int MDW = 256
) (
    input  logic [MDW-1:0] mem_i,
    input  logic [7:0]     mb,
    input  logic [5:0]     bpp,
    output logic [31:0]    color
);
    logic [31:0] mask;

    always_comb begin
        mask  = (bpp >= 6'd32) ? '1 : ((32'd1 << bpp) - 32'd1);
        color = 32'(mem_i >> mb) & mask;
    end
endmodule

module gfx_pixel_rmw_ctrl #(
    parameter int MDW = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic             req_rmw_i,
    input  logic [31:0]      req_adr_i,
    input  logic [7:0]       req_mb_i,
    input  logic [5:0]       req_bpp_i,
    input  logic [31:0]      req_color_i,
    output logic             rsp_valid_o,
    output logic [31:0]      rsp_color_o,
    input  logic             inv_i,
    output logic             m_cyc_o,
    output logic             m_stb_o,
    output logic             m_we_o,
    output logic [31:0]      m_adr_o,
    output logic [MDW/8-1:0] m_sel_o,
    output logic [MDW-1:0]   m_dat_o,
    input  logic             m_ack_i,
    input  logic [MDW-1:0]   m_dat_i
);
    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    state_t state, state_n;

    logic             h_we, h_rmw;
    logic [31:0]      h_adr, h_color;
    logic [7:0]       h_mb;
    logic [5:0]       h_bpp;
    logic             cvalid;
    logic [31:0]      cadr;
    logic [MDW-1:0]   cdata;
    logic             stb_q, we_q, stb_n, we_n;
    logic [31:0]      adr_q, adr_n;
    logic [31:0]      rsp_color_q, rsp_color_n;
    logic             fill, upd;
    logic             req_hit, h_hit, ack;
    logic [MDW-1:0]   c_dat, m2c_mem;
    logic [MDW/8-1:0] c_sel;
    logic [31:0]      m2c_color;
    logic [7:0]       m2c_mb;
    logic [5:0]       m2c_bpp;

    // A same-cycle invalidate must turn an accepting request into a miss.
    assign req_hit = cvalid && !inv_i && (cadr == req_adr_i);
    assign h_hit   = cvalid && (cadr == h_adr);
    assign ack     = m_ack_i && stb_q;

    // Extraction serves both the hit path (cache + live request) and the read-ack path.
    assign m2c_mem = (state == RD) ? m_dat_i : cdata;
    assign m2c_mb  = (state == RD) ? h_mb    : req_mb_i;
    assign m2c_bpp = (state == RD) ? h_bpp   : req_bpp_i;

    memory_to_color #(.MDW(MDW)) u_m2c (
        .mem_i(m2c_mem), .mb(m2c_mb), .bpp(m2c_bpp), .color(m2c_color)
    );

    color_to_memory #(.MDW(MDW)) u_c2m (
        .rmw(h_rmw), .bpp(h_bpp), .color(h_color), .mb(h_mb), .mem_i(cdata),
        .dat(c_dat), .sel(c_sel)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        stb_n       = stb_q;
        we_n        = we_q;
        adr_n       = adr_q;
        rsp_color_n = rsp_color_q;
        fill        = 1'b0;
        upd         = 1'b0;
        case (state)
            IDLE: if (req_valid_i) begin
                adr_n = req_adr_i;
                if (!req_we_i && req_hit) begin
                    state_n     = RSP;
                    rsp_color_n = m2c_color;
                end else if (req_we_i && (!req_rmw_i || req_hit)) begin
                    state_n = WR;
                    stb_n   = 1'b1;
                    we_n    = 1'b1;
                end else begin
                    state_n = RD;
                    stb_n   = 1'b1;
                    we_n    = 1'b0;
                end
            end
            RD: if (ack) begin
                stb_n = 1'b0;
                fill  = 1'b1;
                if (h_we) begin
                    state_n = WR;
                end else begin
                    state_n     = RSP;
                    rsp_color_n = m2c_color;
                end
            end
            WR: if (!stb_q) begin
                // Arrived from RD: strobe re-asserts one edge after the read ack.
                stb_n = 1'b1;
                we_n  = 1'b1;
            end else if (ack) begin
                stb_n       = 1'b0;
                we_n        = 1'b0;
                upd         = !inv_i && (h_hit || h_rmw);
                state_n     = RSP;
                rsp_color_n = '0;
            end
            RSP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            {h_we, h_rmw, h_adr, h_color, h_mb, h_bpp} <= '0;
            {stb_q, we_q, adr_q, rsp_color_q}         <= '0;
            cvalid <= 1'b0;
            cadr   <= '0;
            cdata  <= '0;
        end else begin
            if (req_valid_i && state == IDLE) begin
                h_we    <= req_we_i;
                h_rmw   <= req_rmw_i;
                h_adr   <= req_adr_i;
                h_color <= req_color_i;
                h_mb    <= req_mb_i;
                h_bpp   <= req_bpp_i;
            end
            stb_q       <= stb_n;
            we_q        <= we_n;
            adr_q       <= adr_n;
            rsp_color_q <= rsp_color_n;
            // Read data is always captured so a following merge sees it; validity obeys invalidate.
            if (fill) begin
                cdata <= m_dat_i;
                cadr  <= h_adr;
            end else if (upd) begin
                cdata <= c_dat;
            end
            if (inv_i)     cvalid <= 1'b0;
            else if (fill) cvalid <= 1'b1;
        end
    end

    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == RSP);
    assign rsp_color_o = rsp_color_q;
    assign m_cyc_o     = stb_q;
    assign m_stb_o     = stb_q;
    assign m_we_o      = we_q;
    assign m_adr_o     = adr_q;
    assign m_sel_o     = stb_q ? (we_q ? c_sel : '1) : '0;
    assign m_dat_o     = (stb_q && we_q) ? c_dat : '0;
endmodule

// File: tb/tb_gfx_pixel_rmw_ctrl.sv
// Bench for gfx_pixel_rmw_ctrl: directed scenarios plus random traffic against a
// bit-level pixel/cache/memory reference model; the bench also acts as bus slave.

module tb_gfx_pixel_rmw_ctrl;
    localparam int MDW = 64;
    localparam int SW  = MDW / 8;

    logic           clk_i = 1'b0;
    logic           rst_i, req_valid_i, req_we_i, req_rmw_i, inv_i, m_ack_i;
    logic [31:0]    req_adr_i, req_color_i;
    logic [7:0]     req_mb_i;
    logic [5:0]     req_bpp_i;
    logic [MDW-1:0] m_dat_i;
    logic           req_ready_o, rsp_valid_o, m_cyc_o, m_stb_o, m_we_o;
    logic [31:0]    rsp_color_o, m_adr_o;
    logic [SW-1:0]  m_sel_o;
    logic [MDW-1:0] m_dat_o;

    gfx_pixel_rmw_ctrl #(.MDW(MDW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_rmw_i(req_rmw_i), .req_adr_i(req_adr_i),
        .req_mb_i(req_mb_i), .req_bpp_i(req_bpp_i), .req_color_i(req_color_i),
        .rsp_valid_o(rsp_valid_o), .rsp_color_o(rsp_color_o), .inv_i(inv_i),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
        .m_sel_o(m_sel_o), .m_dat_o(m_dat_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i)
        if (!rst_i && req_valid_i && req_ready_o)
            assert (req_bpp_i != 6'd0) else $error("bpp=0 request issued");

    int n_chk = 0;
    int n_err = 0;

    // Reference state: four memory words at 0x100..0x118 and the one-word cache.
    logic [MDW-1:0] mem [0:3];
    bit             cv_m;
    logic [31:0]    ca_m;
    logic [MDW-1:0] cd_m;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [MDW-1:0] put_pixel(input logic [MDW-1:0] w, input logic [31:0] c,
                                                 input int mb, input int bpp);
        for (int b = 0; b < bpp; b++) if (mb + b < MDW) w[mb+b] = c[b];
        return w;
    endfunction

    function automatic logic [31:0] get_pixel(input logic [MDW-1:0] w, input int mb, input int bpp);
        logic [31:0] c = '0;
        for (int b = 0; b < bpp; b++) if (mb + b < MDW) c[b] = w[mb+b];
        return c;
    endfunction

    function automatic logic [SW-1:0] byte_sel(input bit rmw, input int mb, input int bpp);
        logic [SW-1:0] s = '0;
        if (rmw) return '1;
        for (int k = 0; k < (bpp + 7) / 8; k++) if (mb / 8 + k < SW) s[mb/8+k] = 1'b1;
        return s;
    endfunction

    task automatic idle_cycle();
        @(posedge clk_i); #1;
    endtask

    task automatic do_req(input bit we, input bit rmw, input logic [31:0] adr, input int mb,
                          input int bpp, input logic [31:0] color, input int n, input bit inv_rd);
        bit             hit, exp_rd;
        int             exp_lat, lat, nrd, nwr, cnt, ix;
        logic [31:0]    exp_col;
        logic [MDW-1:0] exp_dat;
        logic [SW-1:0]  exp_sel;
        ix      = int'((adr - 32'h100) >> 3);
        hit     = cv_m && (ca_m == adr);
        exp_rd  = !hit && (!we || rmw);
        exp_lat = (!we && hit) ? 1 : (we && rmw && !hit) ? 2 * n + 4 : n + 2;
        exp_col = we ? 32'h0 : (hit ? get_pixel(cd_m, mb, bpp) : get_pixel(mem[ix], mb, bpp));
        exp_dat = '0;
        exp_sel = '0;
        lat = 0; nrd = 0; nwr = 0; cnt = 0;
        chk("ready", req_ready_o, 1);
        req_valid_i = 1'b1; req_we_i = we; req_rmw_i = rmw; req_adr_i = adr;
        req_mb_i = 8'(mb); req_bpp_i = 6'(bpp); req_color_i = color;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        for (int j = 1; j <= 60 && lat == 0; j++) begin
            if (rsp_valid_o) begin
                lat = j;
                chk("rsp_color", rsp_color_o, exp_col);
                chk("cyc_at_rsp", m_cyc_o, 0);
            end else if (m_stb_o) begin
                if (cnt == 0) begin
                    chk("cyc", m_cyc_o, 1);
                    chk("adr", m_adr_o, adr);
                    if (m_we_o) begin
                        nwr++;
                        exp_dat = put_pixel(cd_m, color, mb, bpp);
                        exp_sel = byte_sel(rmw, mb, bpp);
                        chk("wr_dat", m_dat_o, exp_dat);
                        chk("wr_sel", m_sel_o, exp_sel);
                    end else begin
                        nrd++;
                        chk("rd_sel", m_sel_o, {SW{1'b1}});
                    end
                end
                if (cnt == n) begin
                    m_ack_i = 1'b1;
                    cnt = 0;
                    if (m_we_o) begin
                        for (int k = 0; k < SW; k++)
                            if (exp_sel[k]) mem[ix][8*k +: 8] = exp_dat[8*k +: 8];
                        if (rmw || (cv_m && ca_m == adr)) cd_m = exp_dat;
                    end else begin
                        m_dat_i = mem[ix];
                        if (inv_rd) inv_i = 1'b1;
                        cd_m = mem[ix];
                        ca_m = adr;
                        cv_m = !inv_rd;
                    end
                end else begin
                    cnt++;
                end
            end
            @(posedge clk_i); #1;
            m_ack_i = 1'b0;
            inv_i   = 1'b0;
            m_dat_i = {$urandom, $urandom};
        end
        chk("latency", lat, exp_lat);
        chk("reads", nrd, exp_rd);
        chk("writes", nwr, we);
    endtask

    initial begin
        bit ok;
        rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_rmw_i = 1'b0;
        req_adr_i = '0; req_mb_i = '0; req_bpp_i = 6'd1; req_color_i = '0;
        inv_i = 1'b0; m_ack_i = 1'b0; m_dat_i = '0;
        mem[0] = {$urandom, $urandom};
        mem[1] = '1;
        mem[2] = {$urandom, $urandom};
        mem[3] = {$urandom, $urandom};
        cv_m = 1'b0; ca_m = '0; cd_m = '0;

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", req_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_color", rsp_color_o, 0);
        chk("rst_cyc", m_cyc_o, 0);
        chk("rst_stb", m_stb_o, 0);
        chk("rst_we", m_we_o, 0);
        chk("rst_adr", m_adr_o, 0);
        chk("rst_sel", m_sel_o, 0);
        chk("rst_dat", m_dat_o, 0);
        rst_i = 1'b0;
        idle_cycle();

        // Plain write: 16 bpp at bit 40, no read cycle.
        do_req(1, 0, 32'h100, 40, 16, 32'hABCD1234, 1, 0);
        // Nibble RMW on an all-ones word, then a second RMW to the same word hits.
        do_req(1, 1, 32'h108, 12, 4, 32'h5, 1, 0);
        do_req(1, 1, 32'h108, 0, 4, 32'hA, 0, 0);
        do_req(0, 0, 32'h108, 12, 4, 32'h0, 0, 0);
        chk("mem_rmw_word", mem[1], 64'hFFFF_FFFF_FFFF_5FFA);

        // Invalidate in idle forces a fresh read.
        inv_i = 1'b1; idle_cycle(); inv_i = 1'b0; cv_m = 1'b0;
        do_req(0, 0, 32'h108, 0, 4, 32'h0, 2, 0);
        // Invalidate coinciding with the read ack leaves the cache invalid.
        do_req(0, 0, 32'h110, 8, 12, 32'h0, 0, 1);
        do_req(0, 0, 32'h110, 8, 12, 32'h0, 1, 0);

        // Reset while a write strobe waits for an ack that never comes.
        chk("ready_pre_rst", req_ready_o, 1);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_rmw_i = 1'b0; req_adr_i = 32'h118;
        req_mb_i = 8'd0; req_bpp_i = 6'd8; req_color_i = 32'h3C;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        ok = 1'b0;
        for (int j = 0; j < 10 && !ok; j++) begin
            if (m_stb_o) ok = 1'b1;
            else idle_cycle();
        end
        chk("wr_stb_seen", ok, 1);
        idle_cycle(); idle_cycle();
        chk("wr_stb_held", m_stb_o, 1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("midrst_cyc", m_cyc_o, 0);
        chk("midrst_stb", m_stb_o, 0);
        rst_i = 1'b0;
        cv_m = 1'b0; ca_m = '0; cd_m = '0;
        for (int j = 0; j < 3; j++) begin
            chk("midrst_no_rsp", rsp_valid_o, 0);
            idle_cycle();
        end
        do_req(1, 1, 32'h118, 16, 8, 32'h77, 1, 0);

        // Random traffic over four words.
        for (int it = 0; it < 150; it++) begin
            int bpp, mb;
            bpp = int'($urandom_range(32, 1));
            mb  = int'($urandom_range(MDW - bpp, 0));
            if ($urandom_range(9, 0) == 0) begin
                inv_i = 1'b1; idle_cycle(); inv_i = 1'b0; cv_m = 1'b0;
            end
            do_req(1'($urandom), 1'($urandom), 32'h100 + 32'($urandom_range(3, 0)) * 8,
                   mb, bpp, $urandom, int'($urandom_range(3, 0)),
                   $urandom_range(7, 0) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
